ins_loader: RTL and testbench
=============================

Name: ins_loader

Overview:
- Host-side program loader that writes 32-bit instruction words into the byte-wide, dual-port instruction BRAM.
- It is the writer for the instruction-fetch path that reads that BRAM.
- It accepts a valid/ready word stream, splits each word into four little-endian bytes and writes them over ports A and B in two cycles.
- It holds the CPU (cpu_hold) until a load completes cleanly.

Parameters:
- ADDR_W, 12: BRAM byte-address width. Depth = 2**ADDR_W bytes.
- BASE_ADDR, 0: byte address of the first word. Must be a multiple of 4; a non-aligned value is a configuration error and is not checked.
- Localparam MAX_WORDS = (2**ADDR_W - BASE_ADDR)/4: word capacity.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle pulse that begins a load session.
- s_valid  input  1  stream word valid.
- s_data  input  32  instruction word; byte 0 = s_data[7:0].
- s_last  input  1  marks the final word of the session; qualified by s_valid.
- s_ready  output  1  loader can accept a word.
- ena  output  1  BRAM port A enable.
- wea  output  1  BRAM port A write enable.
- addra  output  ADDR_W  port A byte address.
- dina  output  8  port A write data.
- enb  output  1  BRAM port B enable.
- web  output  1  BRAM port B write enable.
- addrb  output  ADDR_W  port B byte address.
- dinb  output  8  port B write data.
- busy  output  1  a load session is in progress.
- done  output  1  last session completed without error. Sticky until the next load_start or reset.
- error  output  1  last session overflowed. Sticky until the next load_start or reset.
- word_count  output  ADDR_W-1  words written in the current or last session.
- cpu_hold  output  1  stall/hold request to the CPU pipeline.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; the word pointer and latched word are cleared.
  - All outputs are 0 except cpu_hold=1.
  - Assertion mid-write drops wea/web immediately; a partially written word is not completed.
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE: s_ready=0, cpu_hold=1. load_start moves to LOAD and clears word_count, done and error; ptr <= BASE_ADDR.
  - LOAD: s_ready=1, busy=1. On s_valid&&s_ready:
    - if word_count==MAX_WORDS: go to ERR and write nothing;
    - otherwise latch s_data and s_last, go to WR_LO.
    - With no s_valid, stay in LOAD indefinitely.
  - WR_LO: ena=enb=wea=web=1; addra=ptr, dina=word[7:0]; addrb=ptr+1, dinb=word[15:8]. Next state is WR_HI.
  - WR_HI: enables/writes as in WR_LO; addra=ptr+2, dina=word[23:16]; addrb=ptr+3, dinb=word[31:24].
    - On exit: ptr <= ptr+4, word_count <= word_count+1.
    - If latched last=1, go to DONE; otherwise go to LOAD.
  - DONE: done=1, busy=0, cpu_hold=0, s_ready=0. load_start moves to LOAD (re-asserts cpu_hold).
  - ERR: error=1, busy=0, cpu_hold=1, s_ready=0. load_start moves to LOAD.
- Throughput: 3 cycles per word (accept, WR_LO, WR_HI). s_ready is low in WR_LO and WR_HI.
- Port enables outside WR_LO/WR_HI: ena=enb=wea=web=0. addr/din hold their last values; they are don't-care.
- Address arithmetic is ADDR_W bits and never wraps: the overflow check happens before any write.
- load_start while busy (LOAD/WR_LO/WR_HI) is ignored.
- s_valid outside LOAD is ignored; the word is not consumed because s_ready=0.
- s_last arriving with an overflowing word still goes to ERR.
- Port A and port B never address the same byte in one cycle.

Test Plan:
- Reset, load_start, one word 0xDEADBEEF with s_last=1 ->
  - WR_LO: addra=0x000 dina=0xEF, addrb=0x001 dinb=0xBE;
  - WR_HI: addra=0x002 dina=0xAD, addrb=0x003 dinb=0xDE;
  - then done=1, word_count=1, cpu_hold=0.
- Three back-to-back words 0x00000013, 0x00100093, 0x002081B3 (last on third), s_valid held high -> s_ready pulses every 3rd cycle; the final word is written at bytes 0x008..0x00B with dinb=0x00 in WR_HI; word_count=3.
- s_valid deasserted for 10 cycles mid-session -> FSM stays in LOAD, no writes, busy=1, cpu_hold=1; the session resumes with ptr continuing correctly.
- ADDR_W=4, BASE_ADDR=0 (MAX_WORDS=4): send 5 words, last on the 5th ->
  - 4 words written;
  - 5th accepted without write, error=1, done=0, cpu_hold=1, word_count=4;
  - a following load_start clears error.
- Assert rst during WR_LO -> wea=web=0 in the same cycle asynchronously; after release: IDLE, word_count=0, cpu_hold=1, done=0.
- load_start pulsed during WR_HI -> ignored; the session completes normally. load_start in DONE -> new session rewrites from BASE_ADDR with word_count restarting at 0.

Source files
------------

// File: rtl/ins_loader.sv
// Program loader: takes a valid/ready stream of 32-bit instruction words and
// writes each one as four little-endian bytes over both BRAM ports in two cycles.
module ins_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [7:0]        dinb,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count,
  output logic              cpu_hold
);

  localparam int CW        = ADDR_W - 1;
  localparam int MAX_WORDS = (2**ADDR_W - BASE_ADDR) / 4;
  localparam logic [CW-1:0]     MAX_W  = CW'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE_W = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, LOAD, WR_LO, WR_HI, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       word_hi_q, word_hi_d;
  logic              last_q, last_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic [7:0]        dina_q, dina_d, dinb_q, dinb_d;
  logic              wr_phase;

  // Port address/data registers are loaded one cycle ahead of each write phase
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    word_hi_d = word_hi_q;
    last_d    = last_q;
    count_d   = count_q;
    addra_d   = addra_q;
    addrb_d   = addrb_q;
    dina_d    = dina_q;
    dinb_d    = dinb_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
          ptr_d   = BASE_W;
        end
      end
      LOAD: begin
        if (s_valid) begin
          if (count_q == MAX_W) begin
            state_d = ERR;
          end else begin
            state_d   = WR_LO;
            word_hi_d = s_data[31:16];
            last_d    = s_last;
            addra_d   = ptr_q;
            dina_d    = s_data[7:0];
            addrb_d   = ptr_q + ADDR_W'(1);
            dinb_d    = s_data[15:8];
          end
        end
      end
      WR_LO: begin
        state_d = WR_HI;
        addra_d = ptr_q + ADDR_W'(2);
        dina_d  = word_hi_q[7:0];
        addrb_d = ptr_q + ADDR_W'(3);
        dinb_d  = word_hi_q[15:8];
      end
      WR_HI: begin
        ptr_d   = ptr_q + ADDR_W'(4);
        count_d = count_q + CW'(1);
        state_d = last_q ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      word_hi_q <= '0;
      last_q    <= 1'b0;
      count_q   <= '0;
      addra_q   <= '0;
      addrb_q   <= '0;
      dina_q    <= '0;
      dinb_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      word_hi_q <= word_hi_d;
      last_q    <= last_d;
      count_q   <= count_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
      dina_q    <= dina_d;
      dinb_q    <= dinb_d;
    end
  end

  // Status and enables decode purely from the state register
  assign wr_phase   = (state_q == WR_LO) || (state_q == WR_HI);
  assign s_ready    = (state_q == LOAD);
  assign ena        = wr_phase;
  assign enb        = wr_phase;
  assign wea        = wr_phase;
  assign web        = wr_phase;
  assign addra      = addra_q;
  assign addrb      = addrb_q;
  assign dina       = dina_q;
  assign dinb       = dinb_q;
  assign busy       = (state_q == LOAD) || wr_phase;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign word_count = count_q;
  assign cpu_hold   = (state_q != DONE);

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: a default-size instance plus a 16-byte
// instance for the overflow case, sharing the stream inputs.
module tb_ins_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start1, load_start2;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;

  logic        s_ready1, ena1, wea1, enb1, web1, busy1, done1, error1, cpu_hold1;
  logic [11:0] addra1, addrb1;
  logic [7:0]  dina1, dinb1;
  logic [10:0] word_count1;

  logic        s_ready2, ena2, wea2, enb2, web2, busy2, done2, error2, cpu_hold2;
  logic [3:0]  addra2, addrb2;
  logic [7:0]  dina2, dinb2;
  logic [2:0]  word_count2;

  typedef struct packed {
    logic [11:0] aa;
    logic [7:0]  da;
    logic [11:0] ab;
    logic [7:0]  db;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  int  compared = 0;
  int  mismatched = 0;

  ins_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .load_start(load_start1),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready1),
    .ena(ena1), .wea(wea1), .addra(addra1), .dina(dina1),
    .enb(enb1), .web(web1), .addrb(addrb1), .dinb(dinb1),
    .busy(busy1), .done(done1), .error(error1),
    .word_count(word_count1), .cpu_hold(cpu_hold1)
  );

  ins_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .load_start(load_start2),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready2),
    .ena(ena2), .wea(wea2), .addra(addra2), .dina(dina2),
    .enb(enb2), .web(web2), .addrb(addrb2), .dinb(dinb2),
    .busy(busy2), .done(done2), .error(error2),
    .word_count(word_count2), .cpu_hold(cpu_hold2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_write(input int which, input logic [3:0] ens, input wr_t act);
    wr_t exp;
    if ((which == 0 && q1.size() == 0) || (which == 1 && q2.size() == 0)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_write dut%0d: addra=0x%0h dina=0x%0h, expected no write",
               which + 1, act.aa, act.da);
    end else begin
      exp = (which == 0) ? q1.pop_front() : q2.pop_front();
      check($sformatf("dut%0d_enables", which + 1), {28'd0, ens}, 32'hF);
      check($sformatf("dut%0d_addra", which + 1), {20'd0, act.aa}, {20'd0, exp.aa});
      check($sformatf("dut%0d_dina", which + 1), {24'd0, act.da}, {24'd0, exp.da});
      check($sformatf("dut%0d_addrb", which + 1), {20'd0, act.ab}, {20'd0, exp.ab});
      check($sformatf("dut%0d_dinb", which + 1), {24'd0, act.db}, {24'd0, exp.db});
    end
  endtask

  // Monitor: every cycle a port is enabled, pop the next expected write
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ena1 || enb1 || wea1 || web1)
        check_write(0, {ena1, enb1, wea1, web1}, '{addra1, dina1, addrb1, dinb1});
      if (ena2 || enb2 || wea2 || web2)
        check_write(1, {ena2, enb2, wea2, web2},
                    '{{8'd0, addra2}, dina2, {8'd0, addrb2}, dinb2});
    end
  end

  task automatic pulse_start(input int which);
    if (which == 0) load_start1 = 1'b1; else load_start2 = 1'b1;
    @(posedge clk);
    #1;
    load_start1 = 1'b0;
    load_start2 = 1'b0;
  endtask

  task automatic applyStimulus(input int which, input logic [31:0] data, input logic last,
                               input logic [11:0] addr, input bit expect_wr, output int edges);
    logic r;
    bit   got;
    wr_t  lo, hi;
    lo = '{addr, data[7:0], addr + 12'd1, data[15:8]};
    hi = '{addr + 12'd2, data[23:16], addr + 12'd3, data[31:24]};
    if (expect_wr) begin
      if (which == 0) begin q1.push_back(lo); q1.push_back(hi); end
      else begin q2.push_back(lo); q2.push_back(hi); end
    end
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    edges   = 0;
    got     = 1'b0;
    while (!got && edges < 40) begin
      @(negedge clk);
      r = (which == 0) ? s_ready1 : s_ready2;
      @(posedge clk);
      edges++;
      got = r;
    end
    #1;
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout dut%0d: word 0x%0h not accepted, expected acceptance",
               which + 1, data);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    rst = 1'b0;
    load_start1 = 1'b0;
    load_start2 = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready1, 0);
    check("rst_enables", {ena1, enb1, wea1, web1}, 0);
    check("rst_busy", busy1, 0);
    check("rst_done_error", {done1, error1}, 0);
    check("rst_word_count", word_count1, 0);
    check("rst_addr_din", {addra1, addrb1, dina1, dinb1}, 0);
    check("rst_cpu_hold", {cpu_hold1, cpu_hold2}, 2'b11);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word
    pulse_start(0);
    check("t1_s_ready", s_ready1, 1);
    check("t1_busy", busy1, 1);
    check("t1_cpu_hold", cpu_hold1, 1);
    applyStimulus(0, 32'hDEADBEEF, 1'b1, 12'h000, 1'b1, e);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t1_done", done1, 1);
    check("t1_word_count", word_count1, 1);
    check("t1_cpu_hold_release", cpu_hold1, 0);
    check("t1_busy_low", busy1, 0);

    // Back-to-back words, restart from DONE
    pulse_start(0);
    check("t2_word_count_restart", word_count1, 0);
    check("t2_done_cleared", done1, 0);
    applyStimulus(0, 32'h00000013, 1'b0, 12'h000, 1'b1, e);
    applyStimulus(0, 32'h00100093, 1'b0, 12'h004, 1'b1, e);
    check("t2_spacing_w2", e, 3);
    applyStimulus(0, 32'h002081B3, 1'b1, 12'h008, 1'b1, e);
    check("t2_spacing_w3", e, 3);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t2_done", done1, 1);
    check("t2_word_count", word_count1, 3);

    // Stall mid-session
    pulse_start(0);
    applyStimulus(0, 32'h11223344, 1'b0, 12'h000, 1'b1, e);
    s_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t3_stall_busy", busy1, 1);
    check("t3_stall_cpu_hold", cpu_hold1, 1);
    check("t3_stall_s_ready", s_ready1, 1);
    check("t3_stall_word_count", word_count1, 1);
    applyStimulus(0, 32'h55667788, 1'b1, 12'h004, 1'b1, e);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_done", done1, 1);
    check("t3_word_count", word_count1, 2);

    // load_start during WR_HI is ignored
    pulse_start(0);
    applyStimulus(0, 32'hA5A50001, 1'b0, 12'h000, 1'b1, e);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    load_start1 = 1'b1;
    @(posedge clk);
    #1;
    load_start1 = 1'b0;
    check("t4_busy", busy1, 1);
    check("t4_word_count_kept", word_count1, 1);
    applyStimulus(0, 32'h0000C002, 1'b1, 12'h004, 1'b1, e);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t4_done", done1, 1);
    check("t4_word_count", word_count1, 2);

    // Overflow on the 16-byte instance
    pulse_start(1);
    applyStimulus(1, 32'h03020100, 1'b0, 12'h000, 1'b1, e);
    applyStimulus(1, 32'h17161514, 1'b0, 12'h004, 1'b1, e);
    applyStimulus(1, 32'h2B2A2928, 1'b0, 12'h008, 1'b1, e);
    applyStimulus(1, 32'h3F3E3D3C, 1'b0, 12'h00C, 1'b1, e);
    applyStimulus(1, 32'hFFFFFFFF, 1'b1, 12'h000, 1'b0, e);
    s_valid = 1'b0;
    check("t5_error", error2, 1);
    check("t5_done", done2, 0);
    check("t5_cpu_hold", cpu_hold2, 1);
    check("t5_busy", busy2, 0);
    check("t5_s_ready", s_ready2, 0);
    check("t5_word_count", word_count2, 4);
    repeat (3) @(posedge clk);
    #1;
    check("t5_error_sticky", error2, 1);
    pulse_start(1);
    check("t5_error_cleared", error2, 0);
    check("t5_word_count_cleared", word_count2, 0);
    applyStimulus(1, 32'hCAFEF00D, 1'b1, 12'h000, 1'b1, e);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_reload_done", done2, 1);
    check("t5_reload_word_count", word_count2, 1);

    // Asynchronous reset in WR_LO
    pulse_start(0);
    applyStimulus(0, 32'h12345678, 1'b1, 12'h000, 1'b0, e);
    s_valid = 1'b0;
    check("t6_wr_lo_writing", {wea1, web1}, 2'b11);
    rst = 1'b0;
    #1;
    check("t6_async_we_drop", {ena1, enb1, wea1, web1}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_idle_busy", busy1, 0);
    check("t6_idle_s_ready", s_ready1, 0);
    check("t6_word_count", word_count1, 0);
    check("t6_cpu_hold", cpu_hold1, 1);
    check("t6_done", done1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("final_q1_empty", q1.size(), 0);
    check("final_q2_empty", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
